// File: rtl/fpu_issuer.sv
// Request-side controller for en/busy/done FPU units: buffers operand pairs,
// issues one op at a time and returns each result (or a watchdog timeout).
module fpu_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        fu_en,
  output logic [31:0] fu_adata,
  output logic [31:0] fu_bdata,
  input  logic [31:0] fu_result,
  input  logic        fu_done,
  input  logic        fu_busy,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [1:0]    state;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wd;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          push;
  logic          issue;
  logic          slot_free;
  logic          expire;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  // The response slot counts as free when it is being drained this very cycle.
  assign slot_free = !rsp_valid || rsp_ready;
  assign issue     = (state == S_IDLE) && (count != '0) && !fu_busy && slot_free;
  // wd holds (cycles after fu_en) - 1, so this is the TIMEOUT-th cycle; done wins.
  assign expire    = (state == S_WAIT) && !fu_done && (wd == WW'(TIMEOUT - 1));

  // Operands come straight from the FIFO head in the issue cycle, then from the hold registers.
  assign fu_en    = issue;
  assign fu_adata = issue ? mem_a[rd_ptr] : op_a;
  assign fu_bdata = issue ? mem_b[rd_ptr] : op_b;

  // NOTE: storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= cmd_a;
      mem_b[wr_ptr] <= cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wd    <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            op_a  <= mem_a[rd_ptr];
            op_b  <= mem_b[rd_ptr];
            wd    <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (fu_done)     state <= S_IDLE;
          else if (expire) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!fu_busy && !fu_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A reload in the same cycle as a consumer handshake keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else if ((state == S_WAIT) && fu_done) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= fu_result;
      rsp_timeout <= 1'b0;
    end else if (expire) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= QNAN;
      rsp_timeout <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
